// File: rtl/sar_search_pkg.sv
// Shared definitions for successive-approximation controllers.
package sar_search_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } sar_state_t;

endpackage

// File: rtl/magnitude_compare.sv
// Unsigned magnitude comparator built on a single A + ~B + 1 subtraction.
module magnitude_compare #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic [WIDTH:0] sum;
  logic           carry;

  // Carry-out set means no borrow, i.e. a >= b.
  assign sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign carry = sum[WIDTH];
  assign eq    = (sum[WIDTH-1:0] == '0);
  assign gt    = carry & ~eq;
  assign lt    = ~carry;

endmodule

// File: rtl/sar_search.sv
// MSB-first successive-approximation search against a magnitude comparator,
// one probe per clock, terminating early on equality.
//
// state | meaning
// IDLE  | waiting for start; result/steps/early hold the last search
// PROBE | one comparison per cycle, walking bit_idx from MSB to LSB
// DONE  | single-cycle done pulse, then back to IDLE
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           target,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic [WIDTH-1:0]           probe,
  output logic [$clog2(WIDTH+1)-1:0] steps,
  output logic                       early
);

  localparam int IW = $clog2(WIDTH);
  localparam int SW = $clog2(WIDTH+1);

  sar_state_t       state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             early_q, early_d;
  logic             busy_q, done_q;
  logic             cmp_eq, cmp_gt, cmp_lt;

  assign probe = (state_q == PROBE) ? (result_q | (WIDTH'(1) << bit_idx_q)) : '0;

  magnitude_compare #(.WIDTH(WIDTH)) u_cmp (
    .a  (tgt_q),
    .b  (probe),
    .eq (cmp_eq),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    result_d  = result_q;
    bit_idx_d = bit_idx_q;
    steps_d   = steps_q;
    early_d   = early_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d     = target;
          result_d  = '0;
          bit_idx_d = IW'(WIDTH-1);
          steps_d   = '0;
          early_d   = 1'b0;
          state_d   = PROBE;
        end
      end
      PROBE: begin
        steps_d = steps_q + SW'(1);
        if (cmp_eq) begin
          result_d = probe;
          early_d  = (bit_idx_q != '0);
          state_d  = DONE;
        end else begin
          // Target bit set at this position: keep the trial bit.
          if (cmp_gt)      result_d = probe;
          else if (cmp_lt) result_d = result_q;
          if (bit_idx_q == '0) state_d = DONE;
          else                 bit_idx_d = bit_idx_q - IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      result_q  <= '0;
      bit_idx_q <= IW'(WIDTH-1);
      steps_q   <= '0;
      early_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      result_q  <= result_d;
      bit_idx_q <= bit_idx_d;
      steps_q   <= steps_d;
      early_q   <= early_d;
      busy_q    <= (state_d == PROBE);
      done_q    <= (state_d == DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign steps  = steps_q;
  assign early  = early_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: directed cases, randomized targets and a held-start sweep.
module tb_sar_search;

  localparam int W  = 4;
  localparam int SW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  target = '0;
  logic          busy, done, early;
  logic [W-1:0]  result, probe;
  logic [SW-1:0] steps;

  int errors = 0;
  int checks = 0;

  sar_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .target (target),
    .busy   (busy),
    .done   (done),
    .result (result),
    .probe  (probe),
    .steps  (steps),
    .early  (early)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: number of trailing zeros of a nonzero value.
  function automatic int tz(input int t);
    int n = 0;
    while (n < W && ((t >> n) & 1) == 0) n++;
    return n;
  endfunction

  function automatic int ref_steps(input int t);
    return (t == 0) ? W : W - tz(t);
  endfunction

  function automatic int ref_early(input int t);
    return (t != 0 && tz(t) > 0) ? 1 : 0;
  endfunction

  // Probe on bit b keeps the target's bits above b and sets bit b.
  function automatic int ref_probe(input int t, input int b);
    return ((t >> (b + 1)) << (b + 1)) | (1 << b);
  endfunction

  // Entered at a negedge; returns at the negedge of the done cycle.
  task automatic do_search(input int t, input bit hold);
    int ns = ref_steps(t);
    @(negedge clk);
    start  = 1'b1;
    target = W'(t);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int i = 0; i < ns; i++) begin
      @(negedge clk);
      check("busy", busy, 1);
      check("done_early", done, 0);
      check("probe", probe, ref_probe(t, W - 1 - i));
    end
    @(negedge clk);
    check("done", done, 1);
    check("busy_at_done", busy, 0);
    check("result", result, t);
    check("steps", steps, ns);
    check("early", early, ref_early(t));
    check("probe_at_done", probe, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_probe"}, probe, 0);
  endtask

  initial begin
    int pulses;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_probe", probe, 0);
    check("rst_steps", steps, 0);
    check("rst_early", early, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corners.
    do_search(8, 1'b0);
    do_search(5, 1'b0);
    do_search(0, 1'b0);
    do_search(15, 1'b0);
    @(negedge clk);
    check_idle("idle_after");
    check("result_held", result, 15);

    // Reset mid-search aborts with no done pulse.
    start = 1'b1; target = W'(5);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle("abort");
    check("abort_result", result, 0);
    check("abort_steps", steps, 0);
    check("abort_early", early, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    do_search(5, 1'b0);

    // start/target disturbed during PROBE and DONE are ignored.
    @(negedge clk);
    start = 1'b1; target = W'(4);
    @(posedge clk); #1;
    target = W'(3);
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("dist_busy", busy, 1);
      check("dist_probe", probe, ref_probe(4, W - 1 - i));
    end
    @(negedge clk);
    if (done) pulses++;
    check("dist_result", result, 4);
    check("dist_steps", steps, 2);
    check("dist_early", early, 1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) pulses++;
      check("dist_busy_after", busy, 0);
    end
    check("dist_pulses", pulses, 1);

    // Randomized targets.
    for (int i = 0; i < 24; i++) begin
      do_search(int'($urandom_range(0, (1 << W) - 1)), 1'b0);
    end

    // Held-start sweep: each search accepted exactly steps+2 cycles after the last.
    for (int t = 0; t < (1 << W); t++) begin
      do_search(t, 1'b1);
    end
    start = 1'b0;
    @(negedge clk);
    check_idle("sweep_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
